// File: rtl/serial_subtractor_if.sv
`default_nettype none
// serial_subtractor_if: start/busy/done handshake and operand/result bus
// for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// serial_subtractor: LSB-first bit-serial a - b using one full-subtractor
// cell and a borrow flop; result held from done until the next done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  serial_subtractor_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_diff_next;

  assign w_ai        = r_a_sr[0];
  assign w_bi        = r_b_sr[0];
  assign w_d         = w_ai ^ w_bi ^ r_borrow;
  assign w_br_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_diff_next = {w_d, r_diff_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_diff_sr    <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // The DONE cycle accepts a new start so back-to-back runs leave no gap.
          if (bus.start) begin
            r_a_sr    <= bus.a;
            r_b_sr    <= bus.b;
            r_diff_sr <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_diff_sr <= w_diff_next;
          r_a_sr    <= r_a_sr >> 1;
          r_b_sr    <= r_b_sr >> 1;
          r_borrow  <= w_br_next;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_diff       <= w_diff_next;
            r_borrow_out <= w_br_next;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor: directed vectors on an 8-bit and a 4-bit instance,
// expected results queued at issue and checked by per-instance monitors.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done8_unexpected: got done with diff=%0h expected no done at %0t", bus8.diff, $time);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("diff8", 32'(bus8.diff), 32'(e[7:0]));
        check("borrow8", 32'(bus8.borrow_out), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done4_unexpected: got done with diff=%0h expected no done at %0t", bus4.diff, $time);
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        check("diff4", 32'(bus4.diff), 32'(e[3:0]));
        check("borrow4", 32'(bus4.borrow_out), 32'(e[4]));
      end
    end
  end

  // Called at a negedge; start is accepted at the following posedge and
  // the task returns at the negedge after that acceptance edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit push, input logic [8:0] exp);
    int guard;
    guard = 0;
    while (bus8.busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    if (push) q8.push_back(exp);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = (bus8.busy === 1'b1) ? 1 : 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus8.busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    int n;
    int bc;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'd0);
    check("rst_borrow", 32'(bus8.borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(8'h05, 8'h00, 1'b1, {1'b0, 8'h05});
    wait_done8(n, bc);
    check("latency_5m0", 32'(n), 32'd8);
    check("busy_cycles", 32'(bc), 32'd8);
    @(negedge clk);
    check("done_pulse_len", 32'(bus8.done), 32'd0);

    issue8(8'h03, 8'h05, 1'b1, {1'b1, 8'hFE}); wait_done8(n, bc);
    issue8(8'h00, 8'h00, 1'b1, {1'b0, 8'h00}); wait_done8(n, bc);
    issue8(8'hFF, 8'h01, 1'b1, {1'b0, 8'hFE}); wait_done8(n, bc);
    issue8(8'h00, 8'hFF, 1'b1, {1'b1, 8'h01}); wait_done8(n, bc);
    @(negedge clk);

    // Start pulse in mid-run must be ignored.
    issue8(8'h10, 8'h01, 1'b1, {1'b0, 8'h0F});
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(n, bc);
    repeat (12) @(negedge clk);

    // Back-to-back: new start during the DONE cycle.
    issue8(8'h03, 8'h05, 1'b1, {1'b1, 8'hFE});
    wait_done8(n, bc);
    issue8(8'h09, 8'h04, 1'b1, {1'b0, 8'h05});
    check("b2b_busy", 32'(bus8.busy), 32'd1);
    check("held_diff", 32'(bus8.diff), 32'hFE);
    check("held_borrow", 32'(bus8.borrow_out), 32'd1);
    wait_done8(n, bc);
    check("b2b_latency", 32'(n), 32'd8);
    @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    issue8(8'h20, 8'h01, 1'b0, 9'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_diff", 32'(bus8.diff), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(8'h07, 8'h02, 1'b1, {1'b0, 8'h05});
    wait_done8(n, bc);
    check("after_abort_latency", 32'(n), 32'd8);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ed;
        int g;
        ea = 4'(i);
        eb = 4'(j);
        ed = ea - eb;
        bus4.start = 1'b1;
        bus4.a     = ea;
        bus4.b     = eb;
        q4.push_back({(i < j) ? 1'b1 : 1'b0, ed});
        @(negedge clk);
        bus4.start = 1'b0;
        g = 0;
        while (bus4.done !== 1'b1 && g < 20) begin
          @(negedge clk);
          g++;
        end
        if (g >= 20) check("timeout4", 32'(g), 32'd4);
        @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
